// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory responder.
package imem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } rsp_t;

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam rsp_t        FAULT_RSP = '{instr: NOP, err: 1'b1};

endpackage

// File: rtl/imem_array.sv
// imem_array: program storage with one loader write port and a write-first read port.
module imem_array #(
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = (we_i && waddr_i == raddr_i) ? wdata_i : mem_q[raddr_i];

endmodule

// File: rtl/imem_responder.sv
// imem_responder: valid/ready instruction fetch responder over an internal word array.
// Define IMEM_WAIT_EN to insert WAIT_CYCLES wait states per access.
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic        rsp_err,
    input  logic        flush,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

    state_t      state_q, state_d;
    rsp_t        rsp_q, rsp_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rd_addr, rd_data;
    logic        load, fault;
`ifdef IMEM_WAIT_EN
    logic [31:0] cnt_q, cnt_d;
`endif

    // The read happens on the edge into RESP: from IDLE that is the accept edge itself.
    assign rd_addr = state_q == IDLE ? req_addr : addr_q;
    assign fault   = |rd_addr[1:0] || rd_addr >= LIMIT;

    imem_array #(.DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .we_i    (ld_en && ld_addr < LIMIT),
        .waddr_i (ld_addr[AW+1:2]),
        .wdata_i (ld_data),
        .raddr_i (rd_addr[AW+1:2]),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        load    = 1'b0;
`ifdef IMEM_WAIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: if (req_valid) begin
                addr_d = req_addr;
`ifdef IMEM_WAIT_EN
                if (WAIT_CYCLES > 0) begin
                    state_d = WAIT;
                    cnt_d   = 32'(WAIT_CYCLES - 1);
                end else begin
                    state_d = RESP;
                    load    = 1'b1;
                end
`else
                state_d = RESP;
                load    = 1'b1;
`endif
            end
            WAIT: begin
`ifdef IMEM_WAIT_EN
                if (flush) state_d = IDLE;
                else if (cnt_q == '0) begin
                    state_d = RESP;
                    load    = 1'b1;
                end else cnt_d = cnt_q - 32'd1;
`else
                state_d = IDLE;
`endif
            end
            RESP:    if (rsp_ready || flush) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        rsp_d = load ? (fault ? FAULT_RSP : rsp_t'{rd_data, 1'b0}) : rsp_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rsp_q   <= '0;
            addr_q  <= '0;
`ifdef IMEM_WAIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rsp_q   <= rsp_d;
            addr_q  <= addr_d;
`ifdef IMEM_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign req_ready = state_q == IDLE;
    assign rsp_valid = state_q == RESP;
    assign rsp_instr = rsp_q.instr;
    assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: scoreboard-based bench; expected latency follows IMEM_WAIT_EN.
module tb_imem_responder;

    localparam int DEPTH = 256;
    localparam int WC    = 3;
`ifdef IMEM_WAIT_EN
    localparam int LAT = 1 + WC;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, rsp_ready = 1'b1, flush = 1'b0, ld_en = 1'b0;
    logic [31:0] req_addr = '0, ld_addr = '0, ld_data = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_instr;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    int          checks = 0, passed = 0;

    imem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_err   (rsp_err),
        .flush     (flush),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        if (a < 32'(DEPTH * 4)) model[a[$clog2(DEPTH)+1:2]] = d;
        tick;
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a);
        exp_t e;
        if (a[1:0] != 2'b0 || a >= 32'(DEPTH * 4)) e = exp_t'{32'h0000_0013, 1'b1};
        else e = exp_t'{model[a[$clog2(DEPTH)+1:2]], 1'b0};
        sb.push_back(e);
        req_valid = 1'b1; req_addr = a;
        tick;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 1;
        while (!rsp_valid && n < 40) begin
            tick;
            n++;
        end
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        tick;
        checks++; if (req_ready !== 1'b1) $display("FAIL reset req_ready got %b exp 1", req_ready); else passed++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset rsp_valid got %b exp 0", rsp_valid); else passed++;
        checks++; if (rsp_instr !== 32'h0) $display("FAIL reset rsp_instr got %h exp 0", rsp_instr); else passed++;
        checks++; if (rsp_err !== 1'b0) $display("FAIL reset rsp_err got %b exp 0", rsp_err); else passed++;
        rst = 1'b1;
        tick;
    endtask

    task automatic test_fetch;
        logic [31:0] addrs [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_t e;
        int   n;
        load(32'h0, 32'h0050_0093);
        load(32'h4, 32'h00A0_0113);
        load(32'h8, 32'h0020_81B3);
        load(32'hC, 32'h0000_0013);
        rsp_ready = 1'b1;
        foreach (addrs[i]) begin
            issue(addrs[i]);
            wait_rsp(n);
            e = sb.pop_front();
            checks++; if (n !== LAT) $display("FAIL fetch latency addr=%h got %0d exp %0d", addrs[i], n, LAT); else passed++;
            checks++; if (rsp_instr !== e.instr) $display("FAIL fetch instr addr=%h got %h exp %h", addrs[i], rsp_instr, e.instr); else passed++;
            checks++; if (rsp_err !== e.err) $display("FAIL fetch err addr=%h got %b exp %b", addrs[i], rsp_err, e.err); else passed++;
            checks++; if (req_ready !== 1'b0) $display("FAIL fetch req_ready in RESP got %b exp 0", req_ready); else passed++;
            tick;
        end
    endtask

    task automatic test_hold;
        exp_t e;
        int   n;
        rsp_ready = 1'b0;
        issue(32'h4);
        wait_rsp(n);
        e = sb.pop_front();
        checks++; if (n !== LAT) $display("FAIL hold latency got %0d exp %0d", n, LAT); else passed++;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_instr !== e.instr || rsp_err !== e.err)
                $display("FAIL hold cycle %0d got v=%b i=%h e=%b exp v=1 i=%h e=%b", k, rsp_valid, rsp_instr, rsp_err, e.instr, e.err);
            else passed++;
            tick;
        end
        rsp_ready = 1'b1;
        tick;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL hold release got v=%b r=%b exp v=0 r=1", rsp_valid, req_ready); else passed++;
    endtask

    task automatic test_fault;
        logic [31:0] addrs [3] = '{32'h6, 32'(DEPTH * 4), 32'hFFFF_FFFC};
        exp_t e;
        int   n;
        rsp_ready = 1'b1;
        foreach (addrs[i]) begin
            issue(addrs[i]);
            wait_rsp(n);
            e = sb.pop_front();
            checks++; if (n !== LAT) $display("FAIL fault latency addr=%h got %0d exp %0d", addrs[i], n, LAT); else passed++;
            checks++; if (rsp_instr !== e.instr) $display("FAIL fault instr addr=%h got %h exp %h", addrs[i], rsp_instr, e.instr); else passed++;
            checks++; if (rsp_err !== e.err) $display("FAIL fault err addr=%h got %b exp %b", addrs[i], rsp_err, e.err); else passed++;
            tick;
        end
    endtask

    task automatic test_flush;
        exp_t e;
        int   n;
        rsp_ready = 1'b0;
        issue(32'h8);
        void'(sb.pop_back());
        flush = 1'b1;
        tick;
        flush = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL flush got v=%b r=%b exp v=0 r=1", rsp_valid, req_ready); else passed++;
        rsp_ready = 1'b1;
        issue(32'hC);
        wait_rsp(n);
        e = sb.pop_front();
        checks++; if (rsp_instr !== e.instr || rsp_err !== e.err) $display("FAIL flush next got %h/%b exp %h/%b", rsp_instr, rsp_err, e.instr, e.err); else passed++;
        tick;
        flush = 1'b1;
        issue(32'h0);
        flush = 1'b0;
        wait_rsp(n);
        e = sb.pop_front();
        checks++; if (n !== LAT) $display("FAIL flush idle latency got %0d exp %0d", n, LAT); else passed++;
        checks++; if (rsp_instr !== e.instr) $display("FAIL flush idle instr got %h exp %h", rsp_instr, e.instr); else passed++;
        tick;
    endtask

    task automatic test_write_first;
        exp_t e;
        int   n;
        rsp_ready = 1'b1;
        model[1] = 32'hDEAD_BEEF;
        if (LAT == 1) begin
            ld_en = 1'b1; ld_addr = 32'h4; ld_data = 32'hDEAD_BEEF;
            issue(32'h4);
            ld_en = 1'b0;
        end else begin
            issue(32'h4);
            repeat (LAT - 2) tick;
            ld_en = 1'b1; ld_addr = 32'h4; ld_data = 32'hDEAD_BEEF;
            tick;
            ld_en = 1'b0;
        end
        wait_rsp(n);
        e = sb.pop_front();
        checks++; if (rsp_instr !== e.instr) $display("FAIL write_first instr got %h exp %h", rsp_instr, e.instr); else passed++;
        checks++; if (rsp_err !== e.err) $display("FAIL write_first err got %b exp %b", rsp_err, e.err); else passed++;
        tick;
        issue(32'h4);
        wait_rsp(n);
        e = sb.pop_front();
        checks++; if (rsp_instr !== e.instr) $display("FAIL write_first reread got %h exp %h", rsp_instr, e.instr); else passed++;
        tick;
    endtask

    task automatic test_reset_mid;
        exp_t e;
        int   n;
        rsp_ready = 1'b0;
        issue(32'h8);
        wait_rsp(n);
        void'(sb.pop_front());
        checks++; if (rsp_valid !== 1'b1) $display("FAIL reset_mid pre valid got %b exp 1", rsp_valid); else passed++;
        rst = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_mid rsp_valid got %b exp 0", rsp_valid); else passed++;
        checks++; if (rsp_instr !== 32'h0) $display("FAIL reset_mid rsp_instr got %h exp 0", rsp_instr); else passed++;
        checks++; if (req_ready !== 1'b1) $display("FAIL reset_mid req_ready got %b exp 1", req_ready); else passed++;
        tick;
        rst = 1'b1;
        tick;
        load(32'(DEPTH * 4), 32'hBAD0_BAD0);
        rsp_ready = 1'b1;
        issue(32'h0);
        wait_rsp(n);
        e = sb.pop_front();
        checks++; if (n !== LAT) $display("FAIL reset_mid latency got %0d exp %0d", n, LAT); else passed++;
        checks++; if (rsp_instr !== e.instr || rsp_err !== e.err) $display("FAIL reset_mid reread got %h/%b exp %h/%b", rsp_instr, rsp_err, e.instr, e.err); else passed++;
        tick;
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_hold;
        test_fault;
        test_flush;
        test_write_first;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder serving the fetch stage's instruction requests over a valid/ready request/response handshake. It holds the program image in an internal word array and returns one 32-bit instruction per accepted request. Misaligned or out-of-range addresses are flagged. It sits between the fetch unit (initiator) and the program storage, and has a loader port for writing the image.

## Interface
- DEPTH, 256: instruction words stored; power of two.
- WAIT_CYCLES, 2: extra latency cycles per access; used only when IMEM_WAIT_EN is defined.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch presents a request.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address (PC).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  fetch consumes the response.
- rsp_instr  out  32  instruction word.
- rsp_err  out  1  access fault: misaligned or out of range.
- flush  in  1  cancel the in-flight request (taken branch).
- ld_en  in  1  loader write strobe.
- ld_addr  in  32  loader byte address, word-aligned.
- ld_data  in  32  loader write data.

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - WAIT: counting wait states.
  - RESP: rsp_valid=1.
- IDLE to WAIT or RESP: on req_valid && req_ready, the responder captures req_addr. The next state is WAIT if wait states are enabled and WAIT_CYCLES>0, otherwise RESP.
- WAIT: a counter loads WAIT_CYCLES-1 on entry and decrements each cycle. At 0 the FSM goes to RESP.
- Array read happens on the transition into RESP. The responder registers rsp_instr and rsp_err at that point.
- RESP: rsp_valid, rsp_instr and rsp_err are held stable until rsp_ready=1. On that edge the FSM returns to IDLE.
- Fault rules:
  - The fault condition is req_addr[1:0]!=0 or req_addr >= DEPTH*4.
  - On a fault, rsp_err=1 and rsp_instr=32'h00000013 (NOP). No array read occurs.
- Word index is req_addr[$clog2(DEPTH)+1:2].
- flush:
  - In WAIT or RESP, the FSM goes to IDLE on the next edge and the in-flight response is discarded. rsp_valid is 0 in the following cycle.
  - In IDLE, flush is ignored, so a request presented in the same cycle is accepted.
  - In RESP with flush and rsp_ready both high, the handshake completes. The outcome is the same (IDLE).
- Loader:
  - When ld_en=1, mem[ld_addr word index] <= ld_data at the clock edge. This is allowed in any state.
  - Out-of-range loader writes are dropped.
  - A write in the same cycle as the read to the same word returns the new data (write-first).
- Array contents are not cleared by rst.

## Timing
- Reset values:
  - state=IDLE, req_ready=1.
  - rsp_valid=0, rsp_instr=32'h0, rsp_err=0, wait counter=0.
- Reset asserted mid-access drops the access immediately. No response is produced.
- Latency is measured from the accept edge to the first cycle with rsp_valid=1:
  - 1 cycle without wait states.
  - 1+WAIT_CYCLES cycles with wait states.
- Peak throughput is one access per 2 cycles (the IDLE/RESP alternation). req_ready=0 in WAIT and RESP.
- rsp_valid never drops without either a handshake, a flush, or reset.

## Configuration
- IMEM_WAIT_EN:
  - Defined: the WAIT state and wait counter are compiled in, and WAIT_CYCLES applies. WAIT_CYCLES=0 behaves identically to undefined.
  - Undefined: there is no WAIT state or counter, the FSM goes IDLE to RESP directly, and WAIT_CYCLES is ignored.

## Structure
- Package imem_pkg holds:
  - the state typedef (IDLE/WAIT/RESP);
  - the NOP constant 32'h00000013;
  - the fault-response default.
- Sub-module imem_array holds the storage: one synchronous write port (loader) and one read port with write-first bypass.

## Test plan
- Load mem[0..3] = 0x00500093, 0x00A00113, 0x002081B3, 0x00000013. Request addr 0x0, 0x4, 0x8, 0xC with rsp_ready=1 and the macro undefined. Expect each instruction in order with rsp_err=0 and rsp_valid 1 cycle after accept.
- IMEM_WAIT_EN defined, WAIT_CYCLES=3, request 0x4. Expect rsp_valid at accept+4 with rsp_instr=0x00A00113. Hold rsp_ready=0 for 5 cycles and expect stable outputs.
- Request 0x6, then request DEPTH*4. Expect rsp_err=1 and rsp_instr=0x00000013 for both.
- Accept request 0x8 with WAIT_CYCLES=3, then assert flush in the first WAIT cycle. Expect no rsp_valid and req_ready=1 the next cycle. An immediate request 0xC then returns 0x00000013.
- In the cycle of the read for 0x4, write ld_data=0xDEADBEEF to 0x4. Expect rsp_instr=0xDEADBEEF.
- Drop rst for 1 cycle while in RESP. Expect rsp_valid=0, rsp_instr=0 and req_ready=1 immediately. Memory contents are preserved (a re-read of 0x0 returns 0x00500093).
